ps2_key_event_decoder: RTL

Parametrised per-key event decoder between `keyboard_driver` (held PS/2 scan code on `char`) and game logic such as `Uno`.
- Compares the current scan code against a table of NUM_KEYS codes.
- Qualifies press and release with a stability filter.
- Emits exactly one single-cycle pulse per press per channel.
- Tracks the most recently pulsed key.
- Optionally generates typematic auto-repeat pulses while a key is held.

---
 rtl/ps2_key_event_decoder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ps2_key_event_decoder.sv
// Per-key press/release decoder for a held PS/2 scan code: stability filter, one pulse per press, last-key tracking.
// Define KEY_REPEAT_EN to add typematic auto-repeat pulses while a key stays held.
module ps2_key_event_decoder #(
    parameter int NUM_KEYS      = 5,
    parameter int CODE_W        = 8,
    parameter int MIN_STABLE    = 2,
    parameter int REPEAT_DELAY  = 500000,
    parameter int REPEAT_PERIOD = 100000
) (
    input  logic                                            i_clk,
    input  logic                                            i_rst_n,
    input  logic [CODE_W-1:0]                               i_char,
    input  logic [NUM_KEYS*CODE_W-1:0]                      i_key_codes,
    output logic [NUM_KEYS-1:0]                             o_pulse,
    output logic [NUM_KEYS-1:0]                             o_held,
    output logic [((NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1)-1:0] o_last_key,
    output logic                                            o_last_valid
);
    localparam int LK_W  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int CNT_W = $clog2(MIN_STABLE + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HELD = 1'b1
    } state_e;

    logic [CODE_W-1:0]   char_q, char_d;
    state_e              state_q [NUM_KEYS];
    state_e              state_d [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_d [NUM_KEYS];
    logic [NUM_KEYS-1:0] match;
    logic [NUM_KEYS-1:0] press;
    logic [NUM_KEYS-1:0] pulse_q, pulse_d;
    logic [LK_W-1:0]     last_key_q, last_key_d;
    logic                last_valid_q, last_valid_d;

    // A zero table entry disables its channel, so "no key" never matches anything.
    always_comb begin
        char_d = i_char;
        for (int k = 0; k < NUM_KEYS; k++) begin
            match[k] = (i_key_codes[k*CODE_W +: CODE_W] != '0) &&
                       (char_q == i_key_codes[k*CODE_W +: CODE_W]);
        end
    end

    // cnt counts consecutive samples that argue for leaving the current state.
    always_comb begin
        for (int k = 0; k < NUM_KEYS; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            press[k]   = 1'b0;
            if ((state_q[k] == S_IDLE) ? match[k] : !match[k]) begin
                if (cnt_q[k] == CNT_W'(MIN_STABLE - 1)) begin
                    state_d[k] = (state_q[k] == S_IDLE) ? S_HELD : S_IDLE;
                    cnt_d[k]   = '0;
                    press[k]   = (state_q[k] == S_IDLE);
                end else if (cnt_q[k] != CNT_W'(MIN_STABLE)) begin
                    cnt_d[k] = cnt_q[k] + CNT_W'(1);
                end
            end else begin
                cnt_d[k] = '0;
            end
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0]    rpt_q [NUM_KEYS];
    logic [RPT_W-1:0]    rpt_d [NUM_KEYS];
    logic [NUM_KEYS-1:0] rep_q, rep_d;
    logic [NUM_KEYS-1:0] rep_pulse;

    // rep marks that the first repeat has fired, switching the target from delay to period.
    always_comb begin
        for (int k = 0; k < NUM_KEYS; k++) begin
            rpt_d[k]     = rpt_q[k];
            rep_d[k]     = rep_q[k];
            rep_pulse[k] = 1'b0;
            if (press[k]) begin
                rpt_d[k] = '0;
                rep_d[k] = 1'b0;
            end else if (state_q[k] == S_HELD && state_d[k] == S_HELD) begin
                if (rpt_q[k] + RPT_W'(1) == (rep_q[k] ? RPT_W'(REPEAT_PERIOD) : RPT_W'(REPEAT_DELAY))) begin
                    rep_pulse[k] = 1'b1;
                    rpt_d[k]     = '0;
                    rep_d[k]     = 1'b1;
                end else if (rpt_q[k] != '1) begin
                    rpt_d[k] = rpt_q[k] + RPT_W'(1);
                end
            end else begin
                rpt_d[k] = '0;
                rep_d[k] = 1'b0;
            end
        end
        pulse_d = press | rep_pulse;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NUM_KEYS; k++) rpt_q[k] <= '0;
            rep_q <= '0;
        end else begin
            for (int k = 0; k < NUM_KEYS; k++) rpt_q[k] <= rpt_d[k];
            rep_q <= rep_d;
        end
    end
`else
    logic unused_rpt_cfg;

    assign unused_rpt_cfg = (REPEAT_DELAY != 0) ^ (REPEAT_PERIOD != 0);

    always_comb begin
        pulse_d = press;
    end
`endif

    // Descending scan so the lowest pulsing index wins on duplicate codes.
    always_comb begin
        last_key_d   = last_key_q;
        last_valid_d = last_valid_q;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (pulse_d[k]) begin
                last_key_d   = LK_W'(k);
                last_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            char_q       <= '0;
            pulse_q      <= '0;
            last_key_q   <= '0;
            last_valid_q <= 1'b0;
            for (int k = 0; k < NUM_KEYS; k++) begin
                state_q[k] <= S_IDLE;
                cnt_q[k]   <= '0;
            end
        end else begin
            char_q       <= char_d;
            pulse_q      <= pulse_d;
            last_key_q   <= last_key_d;
            last_valid_q <= last_valid_d;
            for (int k = 0; k < NUM_KEYS; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_KEYS; k++) o_held[k] = (state_q[k] == S_HELD);
    end

    assign o_pulse      = pulse_q;
    assign o_last_key   = last_key_q;
    assign o_last_valid = last_valid_q;

endmodule
